posit_accumulator: RTL and testbench



---
 rtl/posit_acc_pkg.sv | 17 +
 rtl/posit_accumulator_adder.sv | 118 +++++++++++
 rtl/posit_accumulator.sv | 134 +++++++++++++
 tb/tb_posit_accumulator.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/posit_acc_pkg.sv
// Shared types and constants for the posit accumulator.
package posit_acc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } acc_state_e;

  localparam int POSIT_N = 32;

  // NaR is the lone sign bit; zero is all clear.
  localparam logic [POSIT_N-1:0] POSIT_NAR  = {1'b1, {(POSIT_N-1){1'b0}}};
  localparam logic [POSIT_N-1:0] POSIT_ZERO = '0;

endpackage

// File: rtl/posit_accumulator_adder.sv
// Combinational posit adder: decode, align, add, normalise, re-encode with
// round-to-nearest-even. Never rounds to zero or NaR; saturates at maxpos/minpos.
module Posit_Adder #(
  parameter int N  = 32,
  parameter int ES = 4
) (
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  output logic [N-1:0] out
);

  localparam int FW   = N - 1 - ES;
  localparam int SW   = FW + 1;
  localparam int EW   = 2 * N;
  localparam int GW   = EW - 1 - SW;
  localparam int VW   = 4 * N;
  localparam int PADW = VW - ES - EW + 1;
  localparam int SCW  = $clog2(N << ES) + 3;

  localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

  function automatic void decode(
    input  logic [N-1:0]           x,
    output logic                   sign,
    output logic signed [SCW-1:0]  scale,
    output logic [SW-1:0]          sig
  );
    logic [N-2:0] rem;
    logic [N-2:0] sh;
    logic         r0;
    logic         stop;
    int           run;
    int           k;
    sign = x[N-1];
    rem  = (N-1)'(sign ? -x : x);
    r0   = rem[N-2];
    run  = 0;
    stop = 1'b0;
    for (int i = N - 2; i >= 0; i--) begin
      if (!stop) begin
        if (rem[i] == r0) run++;
        else stop = 1'b1;
      end
    end
    sh    = rem << (run + 1);
    k     = r0 ? run - 1 : -run;
    scale = SCW'(k * (1 << ES) + int'(sh[N-2 -: ES]));
    sig   = {1'b1, sh[FW-1:0]};
  endfunction

  // frac holds the bits below the (implicit) leading one of the normalised sum.
  function automatic logic [N-1:0] encode(
    input logic                  sign,
    input logic signed [SCW-1:0] scale,
    input logic [EW-2:0]         frac
  );
    logic [VW-1:0] v;
    logic [N-2:0]  body;
    logic          rnd;
    logic          stk;
    int            k;
    k = int'(scale >>> ES);
    if (k > N - 3) begin
      body = '1;
    end else if (k < -(N - 2)) begin
      body = (N-1)'(1);
    end else begin
      v = {scale[ES-1:0], frac, {PADW{1'b0}}};
      if (k >= 0) v = (v >> (k + 2)) | ~({VW{1'b1}} >> (k + 1));
      else        v = (v >> (1 - k)) | (VW'(1) << (VW - 1 + k));
      body = v[VW-1 -: N-1];
      rnd  = v[VW-N];
      stk  = |v[VW-N-1:0];
      body = body + (N-1)'(rnd & (stk | body[0]));
    end
    return sign ? -{1'b0, body} : {1'b0, body};
  endfunction

  logic                  s1, s2, sa, sb;
  logic signed [SCW-1:0] e1, e2, ea, eb, er;
  logic [SW-1:0]         m1, m2, ma, mb;
  logic [EW-1:0]         a_ext, b_ext, b_al, sum;
  logic [EW-2:0]         frac;
  int                    d;
  int                    p;

  always_comb begin
    decode(in1, s1, e1, m1);
    decode(in2, s2, e2, m2);
    // Larger magnitude goes to the A side so the subtraction never goes negative.
    if ((e2 > e1) || ((e2 == e1) && (m2 > m1))) begin
      sa = s2; ea = e2; ma = m2;
      sb = s1; eb = e1; mb = m1;
    end else begin
      sa = s1; ea = e1; ma = m1;
      sb = s2; eb = e2; mb = m2;
    end
    d     = int'(ea) - int'(eb);
    a_ext = {1'b0, ma, {GW{1'b0}}};
    b_ext = {1'b0, mb, {GW{1'b0}}};
    if (d >= EW) b_al = EW'(1);
    else         b_al = (b_ext >> d) | EW'(|(b_ext & ((EW'(1) << d) - EW'(1))));
    sum = (sa == sb) ? a_ext + b_al : a_ext - b_al;
    p = 0;
    for (int i = 0; i < EW; i++) begin
      if (sum[i]) p = i;
    end
    er   = ea + SCW'(p - (EW - 2));
    frac = (EW-1)'(sum << (EW - 1 - p));

    if ((in1 == NAR) || (in2 == NAR)) out = NAR;
    else if (in1 == '0)                out = in2;
    else if (in2 == '0)                out = in1;
    else if (sum == '0)                out = '0;
    else                               out = encode(sa, er, frac);
  end

endmodule

// File: rtl/posit_accumulator.sv
// Streaming posit accumulator around Posit_Adder. Define POSIT_ACC_PIPE_EN to
// register the adder result (2 clocks per add, 1 operand every 2 clocks).
module posit_accumulator
  import posit_acc_pkg::*;
#(
  parameter int N  = POSIT_N,
  parameter int ES = 4,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic [CW-1:0] out_count,
  output logic          out_nar
);

  acc_state_e    state_q, state_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [N-1:0]  op_q, op_d;
  logic          op_v_q, op_v_d;
  logic [CW-1:0] count_q, count_d;
  logic [N-1:0]  add_res;
  logic          accept;
  logic          op_take;
  logic          commit;
  logic [N-1:0]  commit_val;
  logic          busy;
  logic          can_accept;

  Posit_Adder #(.N(N), .ES(ES)) u_adder (
    .in1 (acc_q),
    .in2 (op_q),
    .out (add_res)
  );

`ifdef POSIT_ACC_PIPE_EN
  logic [N-1:0] res_q, res_d;
  logic         res_v_q, res_v_d;

  // Hold the next operand off until the previous sum has landed in acc.
  assign op_take    = op_v_q && !res_v_q;
  assign commit     = res_v_q;
  assign commit_val = res_q;
  assign busy       = op_v_q || res_v_q;
  assign can_accept = !op_v_q;

  always_comb begin
    res_d   = res_q;
    res_v_d = op_take;
    if (op_take) res_d = add_res;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q   <= '0;
      res_v_q <= 1'b0;
    end else begin
      res_q   <= res_d;
      res_v_q <= res_v_d;
    end
  end
`else
  assign op_take    = op_v_q;
  assign commit     = op_v_q;
  assign commit_val = add_res;
  assign busy       = op_v_q;
  assign can_accept = 1'b1;
`endif

  assign in_ready  = (state_q == IDLE) || ((state_q == RUN) && can_accept);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign out_data  = out_valid ? acc_q : POSIT_ZERO;
  assign out_count = out_valid ? count_q : '0;
  assign out_nar   = out_valid && (acc_q == POSIT_NAR);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    op_d    = op_q;
    op_v_d  = op_v_q;
    count_d = count_q;

    if (op_take) op_v_d = 1'b0;
    if (commit) begin
      acc_d   = commit_val;
      count_d = (count_q == '1) ? count_q : count_q + 1'b1;
    end
    if (accept) begin
      op_d   = in_data;
      op_v_d = 1'b1;
    end

    unique case (state_q)
      IDLE, RUN: begin
        if (accept) state_d = in_last ? DRAIN : RUN;
      end
      DRAIN: begin
        if (!busy) state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = POSIT_ZERO;
          count_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= POSIT_ZERO;
      op_q    <= '0;
      op_v_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      op_v_q  <= op_v_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_posit_accumulator.sv
// Scoreboard bench for posit_accumulator: directed sums with hand-computed
// posit results, checked by a monitor as each result is handed off.
module tb_posit_accumulator;

  localparam int N  = 32;
  localparam int CW = 16;
`ifdef POSIT_ACC_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic [CW-1:0] out_count;
  logic          out_nar;

  typedef struct {
    logic [N-1:0]  data;
    logic [CW-1:0] count;
    logic          nar;
  } exp_t;

  exp_t sb_q[$];
  int   check_count = 0;
  int   pass_count  = 0;

  posit_accumulator #(.N(N), .ES(4), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_nar   (out_nar)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  task automatic expectSum(input logic [N-1:0] data, input logic [CW-1:0] count, input logic nar);
    exp_t e;
    e.data  = data;
    e.count = count;
    e.nar   = nar;
    sb_q.push_back(e);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic applyStimulus(input logic [N-1:0] d, input logic last);
    int w = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) checkOutput("accept_ready", in_ready, 1);
    else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic waitValid(input string name);
    int e = 0;
    while (!out_valid && e < 20) begin
      @(posedge clk); #1;
      e++;
    end
    checkOutput(name, e, LAT);
  endtask

  task automatic waitIdle();
    int e = 0;
    while (out_valid && e < 20) begin
      @(posedge clk); #1;
      e++;
    end
    checkOutput("result_released", out_valid, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check_count++;
        $display("[TB] FAIL unexpected_result: got 0x%08h, expected no result", out_data);
      end else begin
        e = sb_q.pop_front();
        checkOutput("sum_data", out_data, e.data);
        checkOutput("sum_count", 32'(out_count), 32'(e.count));
        checkOutput("sum_nar", out_nar, e.nar);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_data", out_data, 0);
    checkOutput("reset_out_count", 32'(out_count), 0);
    checkOutput("reset_out_nar", out_nar, 0);

    $display("[TB] single operand 1.0");
    expectSum(32'h40000000, 1, 1'b0);
    applyStimulus(32'h40000000, 1'b1);
    waitValid("single_latency");
    waitIdle();

    $display("[TB] four back-to-back 1.0");
    expectSum(32'h44000000, 4, 1'b0);
    for (int i = 0; i < 4; i++) begin
`ifndef POSIT_ACC_PIPE_EN
      checkOutput("stream_in_ready", in_ready, 1);
`endif
      applyStimulus(32'h40000000, i == 3);
    end
    waitValid("stream_latency");
    waitIdle();

    $display("[TB] 1.0 + -1.0");
    expectSum(32'h00000000, 2, 1'b0);
    applyStimulus(32'h40000000, 1'b0);
    applyStimulus(32'hC0000000, 1'b1);
    waitValid("cancel_latency");
    waitIdle();

    $display("[TB] NaR propagation");
    expectSum(32'h80000000, 3, 1'b1);
    applyStimulus(32'h40000000, 1'b0);
    applyStimulus(32'h80000000, 1'b0);
    applyStimulus(32'h40000000, 1'b1);
    waitValid("nar_latency");
    waitIdle();

    $display("[TB] 1.0 + 0.25 and 1.0 + -2.0");
    expectSum(32'h40800000, 2, 1'b0);
    applyStimulus(32'h40000000, 1'b0);
    applyStimulus(32'h3C000000, 1'b1);
    waitValid("frac_latency");
    waitIdle();
    expectSum(32'hC0000000, 2, 1'b0);
    applyStimulus(32'h40000000, 1'b0);
    applyStimulus(32'hBE000000, 1'b1);
    waitValid("neg_latency");
    waitIdle();

    $display("[TB] zero operand passes through");
    expectSum(32'hBE000000, 2, 1'b0);
    applyStimulus(32'h00000000, 1'b0);
    applyStimulus(32'hBE000000, 1'b1);
    waitValid("zero_latency");
    waitIdle();

    $display("[TB] result held across stall");
    out_ready = 1'b0;
    expectSum(32'h43000000, 2, 1'b0);
    applyStimulus(32'h40000000, 1'b0);
    applyStimulus(32'h42000000, 1'b1);
    waitValid("hold_latency");
    in_valid = 1'b1;
    in_data  = 32'h40000000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("hold_data", out_data, 32'h43000000);
      checkOutput("hold_valid", out_valid, 1);
      checkOutput("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    waitIdle();
    expectSum(32'h40000000, 1, 1'b0);
    applyStimulus(32'h40000000, 1'b1);
    waitValid("restart_latency");
    waitIdle();

    $display("[TB] reset during RUN");
    applyStimulus(32'h40000000, 1'b0);
    applyStimulus(32'h40000000, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midrun_in_ready", in_ready, 1);
    checkOutput("midrun_out_valid", out_valid, 0);
    expectSum(32'h42000000, 1, 1'b0);
    applyStimulus(32'h42000000, 1'b1);
    waitValid("post_reset_latency");
    waitIdle();

    checkOutput("scoreboard_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
